// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default sizes and command bytes
// used by both the command receiver and the response framer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } state_e;

  localparam int DEF_MAX_BITS   = 8;
  localparam int DEF_PARAMETERS = 6;

  localparam logic [7:0] CMD_RD  = 8'h01;
  localparam logic [7:0] CMD_WR  = 8'h02;
  localparam logic [7:0] CMD_END = 8'h0F;

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte serializer: start bit, LSB-first data, stop and gap fields.
// A load on the final gap cycle chains the next byte with no idle bit.
import uart_pkg::*;

module uart_tx_byte #(
  parameter int MAX_BITS  = DEF_MAX_BITS,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 1
) (
  input  logic                clk_N,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [MAX_BITS-1:0] data_i,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CW =
    $clog2(MAX_BITS + STOP_BITS + GAP_BITS + 1);

  state_e              state_q;
  state_e              state_d;
  logic [CW-1:0]       cnt_q;
  logic [MAX_BITS-1:0] sh_q;
  logic                line_d;
  logic                data_end;
  logic                stop_end;
  logic                gap_end;

  always_comb begin
    data_end = cnt_q == CW'(MAX_BITS - 1);
    stop_end = cnt_q == CW'(STOP_BITS - 1);
    gap_end  = (GAP_BITS == 0) ||
               (cnt_q == CW'(GAP_BITS - 1));
  end

  always_ff @(posedge clk_N or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (load_i) state_d = ST_START;
      ST_START:
        state_d = ST_DATA;
      ST_DATA:
        if (data_end) state_d = ST_STOP;
      ST_STOP:
        if (stop_end) begin
          if (GAP_BITS != 0)
            state_d = ST_GAP;
          else
            state_d = load_i ? ST_START : ST_IDLE;
        end
      ST_GAP:
        if (gap_end)
          state_d = load_i ? ST_START : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = state_q != ST_IDLE;
    done_o = (state_q == ST_GAP && gap_end) ||
             (state_q == ST_STOP && stop_end &&
              GAP_BITS == 0);
    unique case (state_d)
      ST_START: line_d = 1'b0;
      ST_DATA:  line_d = sh_q[0];
      default:  line_d = 1'b1;
    endcase
  end

  // Line is driven from the next state so it is a clean flop output.
  always_ff @(posedge clk_N or posedge rst_i) begin
    if (rst_i) begin
      tx_o  <= 1'b1;
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      tx_o <= line_d;
      if (state_d != state_q) cnt_q <= '0;
      else                    cnt_q <= cnt_q + CW'(1);
      if (state_d == ST_START)
        sh_q <= data_i;
      else if (state_d == ST_DATA)
        sh_q <= sh_q >> 1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Response framer: accepts a multi-byte frame in one handshake and
// feeds bytes MSB-first into the serializer back to back.
import uart_pkg::*;

module uart_tx_framer #(
  parameter int MAX_BITS   = DEF_MAX_BITS,
  parameter int PARAMETERS = DEF_PARAMETERS,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 1
) (
  input  logic                           clk_N,
  input  logic                           rst_i,
  input  logic [MAX_BITS*PARAMETERS-1:0] tx_frame_i,
  input  logic [$clog2(PARAMETERS+1)-1:0] tx_len_i,
  input  logic                           tx_valid_i,
  output logic                           tx_ready_o,
  output logic                           UART_TX,
  output logic                           tx_busy_o,
  output logic                           tx_done_o
);

  localparam int W  = MAX_BITS * PARAMETERS;
  localparam int LW = $clog2(PARAMETERS + 1);

  logic [W-1:0]        frame_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       idx_q;
  logic [LW-1:0]       idx_n;
  logic [LW-1:0]       len_c;
  logic                busy_q;
  logic                done_q;
  logic                acc;
  logic                more;
  logic                ld;
  logic [MAX_BITS-1:0] byte_d;
  logic                b_busy;
  logic                b_done;

  function automatic logic [MAX_BITS-1:0] pick(
    input logic [W-1:0]  f,
    input logic [LW-1:0] i
  );
    logic [W-1:0] s;
    s = f << (int'(i) * MAX_BITS);
    return s[W-1 -: MAX_BITS];
  endfunction

  assign tx_ready_o = ~(busy_q | b_busy);
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;

  // First byte comes straight from the input so its start bit
  // appears right after the accepting edge.
  always_comb begin
    len_c = (tx_len_i > LW'(PARAMETERS)) ?
            LW'(PARAMETERS) : tx_len_i;
    acc    = tx_valid_i & tx_ready_o;
    idx_n  = idx_q + LW'(1);
    more   = busy_q & b_done & (idx_n < len_q);
    ld     = (acc & (len_c != '0)) | more;
    byte_d = acc ? pick(tx_frame_i, '0) :
                   pick(frame_q, idx_n);
  end

  always_ff @(posedge clk_N or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc) begin
        frame_q <= tx_frame_i;
        len_q   <= len_c;
        idx_q   <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        if (len_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (b_done) begin
          if (more) begin
            idx_q <= idx_n;
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  uart_tx_byte #(
    .MAX_BITS  (MAX_BITS),
    .STOP_BITS (STOP_BITS),
    .GAP_BITS  (GAP_BITS)
  ) u_byte (
    .clk_N  (clk_N),
    .rst_i  (rst_i),
    .load_i (ld),
    .data_i (byte_d),
    .tx_o   (UART_TX),
    .busy_o (b_busy),
    .done_o (b_done)
  );

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: waveform-table model, per-cycle compare,
// directed literal checks and randomized frames.
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int NB = 8;
  localparam int NS = 1;
  localparam int NG = 1;
  localparam int NP = 6;

  logic        clk_N = 1'b0;
  logic        rst_i = 1'b1;
  logic        tx_valid_i = 1'b0;
  logic [47:0] tx_frame_i = '0;
  logic [2:0]  tx_len_i = '0;
  logic        tx_ready_o;
  logic        UART_TX;
  logic        tx_busy_o;
  logic        tx_done_o;

  always #5 clk_N = ~clk_N;

  uart_tx_framer dut (
    .clk_N      (clk_N),
    .rst_i      (rst_i),
    .tx_frame_i (tx_frame_i),
    .tx_len_i   (tx_len_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .UART_TX    (UART_TX),
    .tx_busy_o  (tx_busy_o),
    .tx_done_o  (tx_done_o)
  );

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  exp_t q[$];
  exp_t cur = 3'b100;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;
  logic line_buf [0:79];
  logic done_buf [0:79];
  logic busy_buf [0:79];
  logic ref_buf  [0:79];

  function automatic exp_t mk(input logic t, input logic b,
                              input logic d);
    return {t, b, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp,
               $time);
    end
  endtask

  // Expected line/busy/done per cycle after acceptance.
  task automatic push_frame(input logic [47:0] f, input int len);
    int         l;
    logic [7:0] b;
    l = (len > NP) ? NP : len;
    if (l == 0) q.push_back(mk(1'b1, 1'b1, 1'b0));
    for (int n = 0; n < l; n++) begin
      b = f[47 - 8*n -: 8];
      q.push_back(mk(1'b0, 1'b1, 1'b0));
      for (int k = 0; k < NB; k++)
        q.push_back(mk(b[k], 1'b1, 1'b0));
      for (int k = 0; k < NS + NG; k++)
        q.push_back(mk(1'b1, 1'b1, 1'b0));
    end
    q.push_back(mk(1'b1, 1'b0, 1'b1));
  endtask

  initial forever begin
    @(posedge clk_N or posedge rst_i);
    if (rst_i) begin
      q.delete();
      cur = mk(1'b1, 1'b0, 1'b0);
    end else begin
      if (!cur.busy && tx_valid_i)
        push_frame(tx_frame_i, int'(tx_len_i));
      if (q.size() != 0) cur = q.pop_front();
      else               cur = mk(1'b1, 1'b0, 1'b0);
    end
  end

  initial forever begin
    @(negedge clk_N);
    if (cmp_en) begin
      chk("line",  UART_TX,    cur.tx);
      chk("busy",  tx_busy_o,  cur.busy);
      chk("done",  tx_done_o,  cur.done);
      chk("ready", tx_ready_o, !cur.busy);
    end
  end

  task automatic send(input logic [47:0] f, input logic [2:0] l);
    @(negedge clk_N);
    tx_frame_i = f;
    tx_len_i   = l;
    tx_valid_i = 1'b1;
    @(negedge clk_N);
    tx_valid_i = 1'b0;
  endtask

  // Sample i is taken after edge E0+i; valid drives edges vf..vt.
  task automatic capture(input int n, input int vf, input int vt,
                         input bit scr);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk_N);
      line_buf[i] = UART_TX;
      done_buf[i] = tx_done_o;
      busy_buf[i] = tx_busy_o;
      tx_valid_i  = (i + 1 >= vf) && (i + 1 <= vt);
      if (scr) begin
        tx_frame_i = 48'({$urandom(), $urandom()});
        tx_len_i   = 3'($urandom());
      end
    end
  endtask

  function automatic logic [7:0] dec(input int base);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = line_buf[base + 1 + k];
    return r;
  endfunction

  localparam logic [47:0] F1 = 48'h01A5_0000_000F;

  initial begin
    logic [10:0] w1;
    logic [10:0] got;
    logic [7:0]  eb [6];
    int          cnt;
    bit          idle;
    eb = '{8'h01, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h0F};

    @(negedge clk_N);
    chk("rst_line",  UART_TX,    1'b1);
    chk("rst_ready", tx_ready_o, 1'b1);
    chk("rst_busy",  tx_busy_o,  1'b0);
    @(negedge clk_N);
    rst_i  = 1'b0;
    cmp_en = 1'b1;
    repeat (20) @(negedge clk_N);

    send(F1, 3'd1);
    chk("model_len1", q.size(), 11);
    capture(13, -1, -1, 1'b0);
    w1 = 11'b110_0000_0010;
    for (int i = 0; i < 11; i++) got[i] = line_buf[i];
    chk("len1_wave", got, w1);
    chk("len1_done11", done_buf[11], 1'b1);
    chk("len1_busy11", busy_buf[11], 1'b0);
    cnt = 0;
    for (int i = 0; i < 13; i++) cnt += int'(done_buf[i]);
    chk("len1_pulses", cnt, 1);

    send(F1, 3'd6);
    chk("model_len6", q.size(), 66);
    capture(68, 20, 20, 1'b1);
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("len6_start%0d", n), line_buf[n*11], 1'b0);
      chk($sformatf("len6_byte%0d", n), dec(n*11), eb[n]);
    end
    chk("len6_done65", done_buf[65], 1'b0);
    chk("len6_done66", done_buf[66], 1'b1);
    for (int i = 0; i < 68; i++) ref_buf[i] = line_buf[i];

    send(F1, 3'd7);
    capture(68, -1, -1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 68; i++)
      if (line_buf[i] !== ref_buf[i]) cnt++;
    chk("len7_eq_len6", cnt, 0);

    send(F1, 3'd0);
    chk("model_len0", q.size(), 1);
    capture(4, -1, -1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) if (line_buf[i] !== 1'b1) cnt++;
    chk("len0_nolow", cnt, 0);
    chk("len0_busy0", busy_buf[0], 1'b1);
    chk("len0_done0", done_buf[0], 1'b0);
    chk("len0_done1", done_buf[1], 1'b1);

    @(negedge clk_N);
    tx_frame_i = 48'h5A00_0000_0000;
    tx_len_i   = 3'd1;
    tx_valid_i = 1'b1;
    @(negedge clk_N);
    tx_frame_i = 48'hC300_0000_0000;
    capture(26, 1, 12, 1'b0);
    chk("b2b_byte0", dec(0), 8'h5A);
    chk("b2b_idle11", line_buf[11], 1'b1);
    chk("b2b_start12", line_buf[12], 1'b0);
    chk("b2b_byte1", dec(12), 8'hC3);
    chk("b2b_done11", done_buf[11], 1'b1);
    chk("b2b_done23", done_buf[23], 1'b1);
    chk("b2b_done24", done_buf[24], 1'b0);

    send(48'h0000_0000_0000, 3'd2);
    repeat (5) @(posedge clk_N);
    #1 chk("pre_rst_line", UART_TX, 1'b0);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_line",  UART_TX,    1'b1);
    chk("arst_busy",  tx_busy_o,  1'b0);
    chk("arst_ready", tx_ready_o, 1'b1);
    chk("arst_done",  tx_done_o,  1'b0);
    @(negedge clk_N);
    rst_i = 1'b0;
    send({CMD_WR, 40'h0}, 3'd1);
    capture(13, -1, -1, 1'b0);
    chk("post_rst_start", line_buf[0], 1'b0);
    chk("post_rst_byte", dec(0), CMD_WR);
    chk("post_rst_stop", line_buf[9], 1'b1);
    chk("post_rst_done", done_buf[11], 1'b1);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_N);
      tx_frame_i = 48'({$urandom(), $urandom()});
      tx_len_i   = 3'($urandom());
      tx_valid_i = 1'b1;
      @(negedge clk_N);
      idle = 1'b0;
      for (int c = 0; c < 120 && !idle; c++) begin
        if (!cur.busy && q.size() == 0) begin
          idle = 1'b1;
          tx_valid_i = 1'b0;
        end else begin
          tx_valid_i = cur.busy && ($urandom_range(0, 3) == 0);
          tx_frame_i = 48'({$urandom(), $urandom()});
          tx_len_i   = 3'($urandom());
          @(negedge clk_N);
        end
      end
      tx_valid_i = 1'b0;
      if (!idle) chk("rand_timeout", 1'b1, 1'b0);
    end

    repeat (3) @(negedge clk_N);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d",
             errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
